// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / commit bus of the reorder buffer.
// master = core side driving dispatch and completions, slave = the ROB itself.
interface reorder_buffer_if #(
  parameter int NUM_A_REGS = 32,
  parameter int NUM_P_REGS = 64,
  parameter int ROB_SIZE   = 64
);
  localparam int AW = $clog2(NUM_A_REGS);
  localparam int PW = $clog2(NUM_P_REGS);
  localparam int RW = $clog2(ROB_SIZE);

  logic          alloc_ready_o;
  logic          alloc0_valid_i;
  logic [AW-1:0] alloc0_arch_i;
  logic [PW-1:0] alloc0_phys_i;
  logic [PW-1:0] alloc0_old_phys_i;
  logic          alloc0_regwrite_i;
  logic [RW-1:0] alloc0_index_o;
  logic          alloc1_valid_i;
  logic [AW-1:0] alloc1_arch_i;
  logic [PW-1:0] alloc1_phys_i;
  logic [PW-1:0] alloc1_old_phys_i;
  logic          alloc1_regwrite_i;
  logic [RW-1:0] alloc1_index_o;

  logic          cmp0_valid_i;
  logic [RW-1:0] cmp0_index_i;
  logic          cmp1_valid_i;
  logic [RW-1:0] cmp1_index_i;
  logic          cmp2_valid_i;
  logic [RW-1:0] cmp2_index_i;

  logic          ret0_valid_o;
  logic [AW-1:0] ret0_arch_o;
  logic [PW-1:0] ret0_phys_o;
  logic [PW-1:0] ret0_free_phys_o;
  logic          ret0_regwrite_o;
  logic          ret1_valid_o;
  logic [AW-1:0] ret1_arch_o;
  logic [PW-1:0] ret1_phys_o;
  logic [PW-1:0] ret1_free_phys_o;
  logic          ret1_regwrite_o;

  logic [RW:0]   count_o;

  modport master (
    input  alloc_ready_o, alloc0_index_o, alloc1_index_o,
    output alloc0_valid_i, alloc0_arch_i, alloc0_phys_i, alloc0_old_phys_i, alloc0_regwrite_i,
    output alloc1_valid_i, alloc1_arch_i, alloc1_phys_i, alloc1_old_phys_i, alloc1_regwrite_i,
    output cmp0_valid_i, cmp0_index_i, cmp1_valid_i, cmp1_index_i, cmp2_valid_i, cmp2_index_i,
    input  ret0_valid_o, ret0_arch_o, ret0_phys_o, ret0_free_phys_o, ret0_regwrite_o,
    input  ret1_valid_o, ret1_arch_o, ret1_phys_o, ret1_free_phys_o, ret1_regwrite_o,
    input  count_o
  );

  modport slave (
    output alloc_ready_o, alloc0_index_o, alloc1_index_o,
    input  alloc0_valid_i, alloc0_arch_i, alloc0_phys_i, alloc0_old_phys_i, alloc0_regwrite_i,
    input  alloc1_valid_i, alloc1_arch_i, alloc1_phys_i, alloc1_old_phys_i, alloc1_regwrite_i,
    input  cmp0_valid_i, cmp0_index_i, cmp1_valid_i, cmp1_index_i, cmp2_valid_i, cmp2_index_i,
    output ret0_valid_o, ret0_arch_o, ret0_phys_o, ret0_free_phys_o, ret0_regwrite_o,
    output ret1_valid_o, ret1_arch_o, ret1_phys_o, ret1_free_phys_o, ret1_regwrite_o,
    output count_o
  );
endinterface

// File: rtl/reorder_buffer.sv
// Reorder buffer: 2-wide in-order allocate, 3 completion ports, 2-wide in-order retire.
// Optional ROB_FLUSH_EN adds a flush_i port that discards all in-flight entries.
module reorder_buffer #(
  parameter int WORD_SIZE  = 32,
  parameter int NUM_A_REGS = 32,
  parameter int NUM_P_REGS = 64,
  parameter int ROB_SIZE   = 64
) (
  input logic clk_i,
  input logic rst_i,
`ifdef ROB_FLUSH_EN
  input logic flush_i,
`endif
  reorder_buffer_if.slave rob
);
  localparam int AW = $clog2(NUM_A_REGS);
  localparam int PW = $clog2(NUM_P_REGS);
  localparam int RW = $clog2(ROB_SIZE);
  localparam logic [RW:0] READY_MAX = (RW+1)'(ROB_SIZE - 2);

  typedef logic [WORD_SIZE-1:0] word_t;

  function automatic logic [RW-1:0] rob_add(input logic [RW-1:0] idx, input logic [1:0] n);
    return idx + RW'(n);
  endfunction

  logic [ROB_SIZE-1:0] use_q;
  logic [ROB_SIZE-1:0] done_q;
  logic [ROB_SIZE-1:0] regwrite_q;
  logic [AW-1:0]       arch_q     [ROB_SIZE];
  logic [PW-1:0]       phys_q     [ROB_SIZE];
  logic [PW-1:0]       old_phys_q [ROB_SIZE];

  logic [RW-1:0] head_q;
  logic [RW-1:0] tail_q;
  logic [RW:0]   count_q;

  logic          flush;
  logic          alloc_ready;
  logic          fire0, fire1;
  logic [RW-1:0] idx0, idx1, head1;
  logic          ret0, ret1;
  logic [1:0]    nalloc, nret;
  logic          cmp_vld [3];
  logic [RW-1:0] cmp_idx [3];

  logic          ret0_vld_p1, ret1_vld_p1;
  logic [AW-1:0] ret0_arch_p1, ret1_arch_p1;
  logic [PW-1:0] ret0_phys_p1, ret1_phys_p1;
  logic [PW-1:0] ret0_free_p1, ret1_free_p1;
  logic          ret0_rw_p1, ret1_rw_p1;

`ifdef ROB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign cmp_vld[0] = rob.cmp0_valid_i;
  assign cmp_vld[1] = rob.cmp1_valid_i;
  assign cmp_vld[2] = rob.cmp2_valid_i;
  assign cmp_idx[0] = rob.cmp0_index_i;
  assign cmp_idx[1] = rob.cmp1_index_i;
  assign cmp_idx[2] = rob.cmp2_index_i;

  // Dispatch side: lanes compact onto the tail; a lone lane1 takes the tail itself.
  assign alloc_ready = (count_q <= READY_MAX);
  assign fire0       = rob.alloc0_valid_i && alloc_ready && !flush;
  assign fire1       = rob.alloc1_valid_i && alloc_ready && !flush;
  assign idx0        = tail_q;
  assign idx1        = rob_add(tail_q, {1'b0, rob.alloc0_valid_i});
  assign nalloc      = {1'b0, fire0} + {1'b0, fire1};

  // Retire decision on pre-edge state; ret1 never skips a not-done head.
  assign head1 = rob_add(head_q, 2'd1);
  assign ret0  = use_q[head_q] && done_q[head_q];
  assign ret1  = ret0 && use_q[head1] && done_q[head1];
  assign nret  = {1'b0, ret0} + {1'b0, ret1};

  // Stage p0 -> p1: entry state update and registered retire record.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      use_q        <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ret0_vld_p1  <= 1'b0;
      ret1_vld_p1  <= 1'b0;
      ret0_arch_p1 <= '0;
      ret1_arch_p1 <= '0;
      ret0_phys_p1 <= '0;
      ret1_phys_p1 <= '0;
      ret0_free_p1 <= '0;
      ret1_free_p1 <= '0;
      ret0_rw_p1   <= 1'b0;
      ret1_rw_p1   <= 1'b0;
    end else if (flush) begin
      use_q        <= '0;
      done_q       <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ret0_vld_p1  <= 1'b0;
      ret1_vld_p1  <= 1'b0;
      ret0_arch_p1 <= '0;
      ret1_arch_p1 <= '0;
      ret0_phys_p1 <= '0;
      ret1_phys_p1 <= '0;
      ret0_free_p1 <= '0;
      ret1_free_p1 <= '0;
      ret0_rw_p1   <= 1'b0;
      ret1_rw_p1   <= 1'b0;
    end else begin
      // Completions first so that retire-clear and allocate-init take precedence.
      for (int k = 0; k < 3; k++) begin
        if (cmp_vld[k] && use_q[cmp_idx[k]]) done_q[cmp_idx[k]] <= 1'b1;
      end
      if (ret0) begin
        use_q[head_q]  <= 1'b0;
        done_q[head_q] <= 1'b0;
      end
      if (ret1) begin
        use_q[head1]  <= 1'b0;
        done_q[head1] <= 1'b0;
      end
      if (fire0) begin
        use_q[idx0]  <= 1'b1;
        done_q[idx0] <= 1'b0;
      end
      if (fire1) begin
        use_q[idx1]  <= 1'b1;
        done_q[idx1] <= 1'b0;
      end
      head_q  <= rob_add(head_q, nret);
      tail_q  <= rob_add(tail_q, nalloc);
      count_q <= count_q + (RW+1)'(nalloc) - (RW+1)'(nret);

      ret0_vld_p1  <= ret0;
      ret1_vld_p1  <= ret1;
      ret0_arch_p1 <= ret0 ? arch_q[head_q]     : '0;
      ret0_phys_p1 <= ret0 ? phys_q[head_q]     : '0;
      ret0_free_p1 <= ret0 ? old_phys_q[head_q] : '0;
      ret0_rw_p1   <= ret0 && regwrite_q[head_q];
      ret1_arch_p1 <= ret1 ? arch_q[head1]      : '0;
      ret1_phys_p1 <= ret1 ? phys_q[head1]      : '0;
      ret1_free_p1 <= ret1 ? old_phys_q[head1]  : '0;
      ret1_rw_p1   <= ret1 && regwrite_q[head1];
    end
  end

  // Payload is only meaningful while use=1, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (fire0) begin
      arch_q[idx0]     <= rob.alloc0_arch_i;
      phys_q[idx0]     <= rob.alloc0_phys_i;
      old_phys_q[idx0] <= rob.alloc0_old_phys_i;
      regwrite_q[idx0] <= rob.alloc0_regwrite_i;
    end
    if (fire1) begin
      arch_q[idx1]     <= rob.alloc1_arch_i;
      phys_q[idx1]     <= rob.alloc1_phys_i;
      old_phys_q[idx1] <= rob.alloc1_old_phys_i;
      regwrite_q[idx1] <= rob.alloc1_regwrite_i;
    end
  end

  assign rob.alloc_ready_o    = alloc_ready;
  assign rob.alloc0_index_o   = idx0;
  assign rob.alloc1_index_o   = idx1;
  assign rob.count_o          = count_q;
  assign rob.ret0_valid_o     = ret0_vld_p1;
  assign rob.ret0_arch_o      = ret0_arch_p1;
  assign rob.ret0_phys_o      = ret0_phys_p1;
  assign rob.ret0_free_phys_o = ret0_free_p1;
  assign rob.ret0_regwrite_o  = ret0_rw_p1;
  assign rob.ret1_valid_o     = ret1_vld_p1;
  assign rob.ret1_arch_o      = ret1_arch_p1;
  assign rob.ret1_phys_o      = ret1_phys_p1;
  assign rob.ret1_free_phys_o = ret1_free_p1;
  assign rob.ret1_regwrite_o  = ret1_rw_p1;
endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: allocations push expected retire records,
// a negedge monitor pops and compares every retire the DUT presents.
module tb_reorder_buffer;
  localparam int ROB = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int m_tail = 0;

  typedef struct {
    int arch;
    int phys;
    int free_p;
    bit rw;
  } ret_t;
  ret_t exp_q[$];

  reorder_buffer_if #(.NUM_A_REGS(32), .NUM_P_REGS(64), .ROB_SIZE(ROB)) bus ();

  reorder_buffer #(.WORD_SIZE(32), .NUM_A_REGS(32), .NUM_P_REGS(64), .ROB_SIZE(ROB)) dut (
    .clk_i (clk),
    .rst_i (rst),
`ifdef ROB_FLUSH_EN
    .flush_i (flush),
`endif
    .rob   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_ret(input int lane, input logic [4:0] arch, input logic [5:0] phys,
                           input logic [5:0] free_p, input logic rw);
    ret_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_retire lane%0d: got arch %0d phys %0d, expected none", lane, arch, phys);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("ret%0d_arch", lane), 32'(arch), 32'(e.arch));
      chk($sformatf("ret%0d_phys", lane), 32'(phys), 32'(e.phys));
      chk($sformatf("ret%0d_regwrite", lane), 32'(rw), 32'(e.rw));
      if (e.rw) chk($sformatf("ret%0d_free_phys", lane), 32'(free_p), 32'(e.free_p));
    end
  endtask

  // Monitor: every retire beat is checked against program order.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ret1_valid_o && !bus.ret0_valid_o) begin
        n_cmp++;
        n_err++;
        $display("FAIL ret1_without_ret0: got ret1_valid 1 with ret0_valid 0, expected ret0 first");
      end
      if (bus.ret0_valid_o)
        check_ret(0, bus.ret0_arch_o, bus.ret0_phys_o, bus.ret0_free_phys_o, bus.ret0_regwrite_o);
      if (bus.ret1_valid_o)
        check_ret(1, bus.ret1_arch_o, bus.ret1_phys_o, bus.ret1_free_phys_o, bus.ret1_regwrite_o);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.alloc0_valid_i = 1'b0; bus.alloc1_valid_i = 1'b0;
    bus.alloc0_arch_i = '0; bus.alloc0_phys_i = '0; bus.alloc0_old_phys_i = '0; bus.alloc0_regwrite_i = 1'b0;
    bus.alloc1_arch_i = '0; bus.alloc1_phys_i = '0; bus.alloc1_old_phys_i = '0; bus.alloc1_regwrite_i = 1'b0;
    bus.cmp0_valid_i = 1'b0; bus.cmp0_index_i = '0;
    bus.cmp1_valid_i = 1'b0; bus.cmp1_index_i = '0;
    bus.cmp2_valid_i = 1'b0; bus.cmp2_index_i = '0;
  endtask

  task automatic alloc(input bit v0, input bit v1,
                       input int a0, input int p0, input int o0, input bit w0,
                       input int a1, input int p1, input int o1, input bit w1,
                       input bit accept);
    ret_t e;
    bus.alloc0_valid_i = v0; bus.alloc0_arch_i = 5'(a0); bus.alloc0_phys_i = 6'(p0);
    bus.alloc0_old_phys_i = 6'(o0); bus.alloc0_regwrite_i = w0;
    bus.alloc1_valid_i = v1; bus.alloc1_arch_i = 5'(a1); bus.alloc1_phys_i = 6'(p1);
    bus.alloc1_old_phys_i = 6'(o1); bus.alloc1_regwrite_i = w1;
    #1;
    if (accept) begin
      if (v0) chk("alloc0_index", 32'(bus.alloc0_index_o), 32'(m_tail));
      if (v1) chk("alloc1_index", 32'(bus.alloc1_index_o), 32'((m_tail + int'(v0)) % ROB));
      if (v0) begin e.arch = a0; e.phys = p0; e.free_p = o0; e.rw = w0; exp_q.push_back(e); end
      if (v1) begin e.arch = a1; e.phys = p1; e.free_p = o1; e.rw = w1; exp_q.push_back(e); end
      m_tail = (m_tail + int'(v0) + int'(v1)) % ROB;
    end
    step();
    bus.alloc0_valid_i = 1'b0;
    bus.alloc1_valid_i = 1'b0;
  endtask

  // Payload derived from an instruction id so each retire record is distinct.
  task automatic alloc_id(input bit v0, input bit v1, input int id0, input int id1, input bit accept);
    alloc(v0, v1, id0 % 32, id0 % 64, (id0 * 3 + 1) % 64, (id0 % 4) != 3,
                  id1 % 32, id1 % 64, (id1 * 3 + 1) % 64, (id1 % 4) != 3, accept);
  endtask

  task automatic cmp3(input bit v0, input int i0, input bit v1, input int i1, input bit v2, input int i2);
    bus.cmp0_valid_i = v0; bus.cmp0_index_i = 6'(i0 % ROB);
    bus.cmp1_valid_i = v1; bus.cmp1_index_i = 6'(i1 % ROB);
    bus.cmp2_valid_i = v2; bus.cmp2_index_i = 6'(i2 % ROB);
    step();
    bus.cmp0_valid_i = 1'b0; bus.cmp1_valid_i = 1'b0; bus.cmp2_valid_i = 1'b0;
  endtask

  task automatic complete_range(input int start, input int n);
    for (int j = 0; j < n; j += 3)
      cmp3(1'b1, start + j, (j + 1) < n, start + j + 1, (j + 2) < n, start + j + 2);
  endtask

  task automatic wait_empty(input string name);
    int c = 0;
    while (bus.count_o != 0 && c < 300) begin
      step();
      c++;
    end
    chk(name, 32'(bus.count_o), 32'd0);
  endtask

  task automatic do_reset(input string name);
    clear_inputs();
    #2 rst = 1'b1;
    #1;
    chk({name, "_count"}, 32'(bus.count_o), 32'd0);
    chk({name, "_ret0_valid"}, 32'(bus.ret0_valid_o), 32'd0);
    chk({name, "_ret1_valid"}, 32'(bus.ret1_valid_o), 32'd0);
    exp_q.delete();
    m_tail = 0;
    step();
    rst = 1'b0;
    #1;
    chk({name, "_ready"}, 32'(bus.alloc_ready_o), 32'd1);
    chk({name, "_index0"}, 32'(bus.alloc0_index_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;

    // Reset state
    chk("reset_count", 32'(bus.count_o), 32'd0);
    chk("reset_ready", 32'(bus.alloc_ready_o), 32'd1);
    chk("reset_ret0_valid", 32'(bus.ret0_valid_o), 32'd0);
    chk("reset_ret1_valid", 32'(bus.ret1_valid_o), 32'd0);
    chk("reset_index0", 32'(bus.alloc0_index_o), 32'd0);

    // Out-of-order completion, in-order dual retire
    alloc(1, 1, 5, 40, 5, 1, 6, 41, 6, 1, 1);
    chk("t2_count", 32'(bus.count_o), 32'd2);
    cmp3(1, 1, 0, 0, 0, 0);
    chk("t2_hold_ret0_a", 32'(bus.ret0_valid_o), 32'd0);
    step();
    chk("t2_hold_ret0_b", 32'(bus.ret0_valid_o), 32'd0);
    chk("t2_hold_count", 32'(bus.count_o), 32'd2);
    cmp3(0, 0, 0, 0, 1, 0);
    chk("t2_latency_ret0", 32'(bus.ret0_valid_o), 32'd0);
    step();
    chk("t2_ret0_valid", 32'(bus.ret0_valid_o), 32'd1);
    chk("t2_ret1_valid", 32'(bus.ret1_valid_o), 32'd1);
    chk("t2_count_after", 32'(bus.count_o), 32'd0);

    // Fill to full, dropped valids, count=63 boundary, drain
    do_reset("t3_rst");
    for (int i = 0; i < 32; i++) begin
      alloc_id(1, 1, 2 * i, 2 * i + 1, 1);
      if (i == 30) begin
        chk("t3_count62", 32'(bus.count_o), 32'd62);
        chk("t3_ready62", 32'(bus.alloc_ready_o), 32'd1);
      end
    end
    chk("t3_count_full", 32'(bus.count_o), 32'd64);
    chk("t3_ready_full", 32'(bus.alloc_ready_o), 32'd0);
    alloc_id(1, 1, 99, 98, 0);
    chk("t3_count_dropped", 32'(bus.count_o), 32'd64);
    cmp3(1, 0, 0, 0, 0, 0);
    step();
    chk("t3_count63", 32'(bus.count_o), 32'd63);
    chk("t3_ready63", 32'(bus.alloc_ready_o), 32'd0);
    alloc_id(1, 0, 97, 0, 0);
    chk("t3_count63_dropped", 32'(bus.count_o), 32'd63);
    complete_range(1, 63);
    wait_empty("t3_drain");

    // Wrap-around at head=tail=62
    do_reset("t4_rst");
    for (int i = 0; i < 31; i++) alloc_id(1, 1, 100 + 2 * i, 101 + 2 * i, 1);
    complete_range(0, 62);
    wait_empty("t4_pre_drain");
    chk("t4_tail62", 32'(bus.alloc0_index_o), 32'd62);
    alloc_id(1, 1, 200, 201, 1);
    alloc_id(1, 1, 202, 203, 1);
    chk("t4_count4", 32'(bus.count_o), 32'd4);
    cmp3(1, 62, 1, 63, 1, 0);
    cmp3(0, 0, 0, 0, 1, 1);
    chk("t4_first_pair_ret0", 32'(bus.ret0_valid_o), 32'd1);
    chk("t4_first_pair_ret1", 32'(bus.ret1_valid_o), 32'd1);
    chk("t4_count2", 32'(bus.count_o), 32'd2);
    step();
    chk("t4_second_pair_ret1", 32'(bus.ret1_valid_o), 32'd1);
    chk("t4_count0", 32'(bus.count_o), 32'd0);
    chk("t4_head2", 32'(bus.alloc0_index_o), 32'd2);

    // Same-edge allocate + retire, completion on the next head
    do_reset("t5_rst");
    for (int i = 0; i < 5; i++) alloc_id(1, 1, 300 + 2 * i, 301 + 2 * i, 1);
    chk("t5_count10", 32'(bus.count_o), 32'd10);
    cmp3(1, 0, 1, 1, 0, 0);
    bus.cmp0_valid_i = 1'b1;
    bus.cmp0_index_i = 6'd2;
    alloc_id(1, 1, 310, 311, 1);
    bus.cmp0_valid_i = 1'b0;
    chk("t5_count_same_edge", 32'(bus.count_o), 32'd10);
    chk("t5_ret1_same_edge", 32'(bus.ret1_valid_o), 32'd1);
    step();
    chk("t5_head_cmp_ret0", 32'(bus.ret0_valid_o), 32'd1);
    chk("t5_head_cmp_ret1", 32'(bus.ret1_valid_o), 32'd0);
    chk("t5_count9", 32'(bus.count_o), 32'd9);
    complete_range(3, 9);
    wait_empty("t5_drain");

    // Reset asserted with done entries in flight
    alloc_id(1, 1, 400, 401, 1);
    alloc_id(1, 1, 402, 403, 1);
    alloc_id(1, 0, 404, 0, 1);
    cmp3(1, 12, 1, 13, 0, 0);
    do_reset("t6_midrst");
    step();
    chk("t6_no_ghost_ret0", 32'(bus.ret0_valid_o), 32'd0);
    chk("t6_no_ghost_count", 32'(bus.count_o), 32'd0);

`ifdef ROB_FLUSH_EN
    // Flush overrides allocate, completion and retire on the same edge
    alloc_id(1, 1, 500, 501, 1);
    alloc_id(1, 1, 502, 503, 1);
    alloc_id(1, 0, 504, 0, 1);
    cmp3(1, 0, 0, 0, 0, 0);
    flush = 1'b1;
    bus.cmp0_valid_i = 1'b1;
    bus.cmp0_index_i = 6'd1;
    alloc_id(1, 0, 505, 0, 0);
    flush = 1'b0;
    bus.cmp0_valid_i = 1'b0;
    exp_q.delete();
    m_tail = 0;
    chk("t6_flush_count", 32'(bus.count_o), 32'd0);
    chk("t6_flush_ret0", 32'(bus.ret0_valid_o), 32'd0);
    chk("t6_flush_index0", 32'(bus.alloc0_index_o), 32'd0);
    step();
    chk("t6_flush_after_ret0", 32'(bus.ret0_valid_o), 32'd0);
`endif

    step();
    step();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
